// File: rtl/wb_arbiter_pkg.sv
//==============================================================================
// Module   : wb_arbiter_pkg
// Purpose  : Shared grant encoding and default sizing for the 2-master arbiter.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

package wb_arbiter_pkg;

    localparam logic [1:0] GNT_NONE = 2'b00;
    localparam logic [1:0] GNT_M0   = 2'b01;
    localparam logic [1:0] GNT_M1   = 2'b10;

    localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 255;
    localparam int unsigned DEFAULT_CNT_WIDTH      = 8;

endpackage

`default_nettype wire

// File: rtl/wb_timeout_counter.sv
//==============================================================================
// Module   : wb_timeout_counter
// Purpose  : Saturating cycle counter with clear and terminal-count pulse.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module wb_timeout_counter #(
    parameter int unsigned TERMINAL  = 255,
    parameter int unsigned CNT_WIDTH = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_tc
);

    generate
        if (TERMINAL == 0) begin : g_disabled
            assign o_tc = 1'b0;
        end else begin : g_enabled
            localparam logic [CNT_WIDTH-1:0] c_terminal = CNT_WIDTH'(TERMINAL);

            logic [CNT_WIDTH-1:0] r_count;

            // Holds at the terminal value so a stalled bus reports only once.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_count <= '0;
                end else if (i_clear) begin
                    r_count <= '0;
                end else if (i_enable && (r_count != c_terminal)) begin
                    r_count <= r_count + 1'b1;
                end
            end

            assign o_tc = i_enable && !i_clear && (r_count == c_terminal);
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/wishbone_arbiter_2m1s.sv
//==============================================================================
// Module   : wishbone_arbiter_2m1s
// Purpose  : Round-robin 2-master / 1-slave Wishbone arbiter with bus timeout.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module wishbone_arbiter_2m1s
    import wb_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
    parameter int unsigned CNT_WIDTH      = DEFAULT_CNT_WIDTH
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_n_i,

    input  logic [31:0] m0_dat_i,
    input  logic [31:0] m0_adr_i,
    input  logic [3:0]  m0_sel_i,
    input  logic        m0_we_i,
    input  logic        m0_cyc_i,
    input  logic        m0_stb_i,
    output logic [31:0] m0_dat_o,
    output logic        m0_ack_o,
    output logic        m0_err_o,

    input  logic [31:0] m1_dat_i,
    input  logic [31:0] m1_adr_i,
    input  logic [3:0]  m1_sel_i,
    input  logic        m1_we_i,
    input  logic        m1_cyc_i,
    input  logic        m1_stb_i,
    output logic [31:0] m1_dat_o,
    output logic        m1_ack_o,
    output logic        m1_err_o,

    output logic [31:0] s_dat_o,
    output logic [31:0] s_adr_o,
    output logic [3:0]  s_sel_o,
    output logic        s_we_o,
    output logic        s_cyc_o,
    output logic        s_stb_o,
    input  logic [31:0] s_dat_i,
    input  logic        s_ack_i,
    input  logic        s_err_i
);

    logic [1:0] r_grant;
    logic [1:0] w_grant_nxt;
    logic [1:0] r_last_grant;
    logic [1:0] w_last_grant_nxt;
    logic       r_timed_out;

    logic       w_gnt_m0;
    logic       w_gnt_m1;
    logic       w_gnt_stb;
    logic       w_tmo_clear;
    logic       w_tmo_enable;
    logic       w_timeout_err;

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            r_grant      <= GNT_NONE;
            r_last_grant <= GNT_M1;
        end else begin
            r_grant      <= w_grant_nxt;
            r_last_grant <= w_last_grant_nxt;
        end
    end

    // An owner always releases to NONE first, so ownership never swaps
    // without an idle cycle on the slave.
    always_comb begin
        w_grant_nxt      = r_grant;
        w_last_grant_nxt = r_last_grant;
        case (r_grant)
            GNT_NONE: begin
                if (m0_cyc_i && (!m1_cyc_i || (r_last_grant == GNT_M1))) begin
                    w_grant_nxt = GNT_M0;
                end else if (m1_cyc_i && (!m0_cyc_i || (r_last_grant == GNT_M0))) begin
                    w_grant_nxt = GNT_M1;
                end
            end
            GNT_M0: begin
                if (!m0_cyc_i) begin
                    w_grant_nxt      = GNT_NONE;
                    w_last_grant_nxt = GNT_M0;
                end
            end
            GNT_M1: begin
                if (!m1_cyc_i) begin
                    w_grant_nxt      = GNT_NONE;
                    w_last_grant_nxt = GNT_M1;
                end
            end
            default: begin
                w_grant_nxt = GNT_NONE;
            end
        endcase
    end

    assign w_gnt_m0 = (r_grant == GNT_M0);
    assign w_gnt_m1 = (r_grant == GNT_M1);

    always_comb begin
        s_cyc_o   = 1'b0;
        w_gnt_stb = 1'b0;
        s_we_o    = 1'b0;
        s_sel_o   = '0;
        s_adr_o   = '0;
        s_dat_o   = '0;
        case (r_grant)
            GNT_M0: begin
                s_cyc_o   = m0_cyc_i;
                w_gnt_stb = m0_stb_i;
                s_we_o    = m0_we_i;
                s_sel_o   = m0_sel_i;
                s_adr_o   = m0_adr_i;
                s_dat_o   = m0_dat_i;
            end
            GNT_M1: begin
                s_cyc_o   = m1_cyc_i;
                w_gnt_stb = m1_stb_i;
                s_we_o    = m1_we_i;
                s_sel_o   = m1_sel_i;
                s_adr_o   = m1_adr_i;
                s_dat_o   = m1_dat_i;
            end
            default: begin
                s_cyc_o   = 1'b0;
            end
        endcase
    end

    // Once timed out, the slave must not see further strobes from this owner.
    assign s_stb_o = w_gnt_stb && !r_timed_out;

    assign m0_dat_o = s_dat_i;
    assign m1_dat_o = s_dat_i;
    assign m0_ack_o = w_gnt_m0 && s_ack_i;
    assign m1_ack_o = w_gnt_m1 && s_ack_i;
    assign m0_err_o = w_gnt_m0 && (s_err_i || w_timeout_err);
    assign m1_err_o = w_gnt_m1 && (s_err_i || w_timeout_err);

    // A slave response in the terminal cycle clears the counter and thereby
    // suppresses the timeout pulse.
    assign w_tmo_clear  = (w_grant_nxt != r_grant) || (r_grant == GNT_NONE)
                        || s_ack_i || s_err_i || !w_gnt_stb;
    assign w_tmo_enable = (r_grant != GNT_NONE) && w_gnt_stb && !r_timed_out;

    wb_timeout_counter #(
        .TERMINAL  (TIMEOUT_CYCLES),
        .CNT_WIDTH (CNT_WIDTH)
    ) u_timeout (
        .clk      (wb_clk_i),
        .rst_n    (wb_rst_n_i),
        .i_clear  (w_tmo_clear),
        .i_enable (w_tmo_enable),
        .o_tc     (w_timeout_err)
    );

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            r_timed_out <= 1'b0;
        end else if (w_grant_nxt == GNT_NONE) begin
            r_timed_out <= 1'b0;
        end else if (w_timeout_err) begin
            r_timed_out <= 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_wishbone_arbiter_2m1s.sv
//==============================================================================
// Module   : tb_wishbone_arbiter_2m1s
// Purpose  : Directed self-checking bench for the 2-master Wishbone arbiter.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_wishbone_arbiter_2m1s;

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_n_i;
    logic [31:0] m0_dat_i, m0_adr_i, m1_dat_i, m1_adr_i;
    logic [3:0]  m0_sel_i, m1_sel_i;
    logic        m0_we_i, m0_cyc_i, m0_stb_i, m1_we_i, m1_cyc_i, m1_stb_i;
    logic [31:0] m0_dat_o, m1_dat_o, s_dat_o, s_adr_o, s_dat_i;
    logic        m0_ack_o, m0_err_o, m1_ack_o, m1_err_o;
    logic [3:0]  s_sel_o;
    logic        s_we_o, s_cyc_o, s_stb_o, s_ack_i, s_err_i;

    logic [31:0] ram [0:15];
    logic        ram_ack;
    logic [31:0] ram_rdata;
    logic        ram_en;
    logic        force_ack;
    logic        force_err;

    int n_checks = 0;
    int n_fails  = 0;

    always #5 wb_clk_i = ~wb_clk_i;

    wishbone_arbiter_2m1s #(
        .TIMEOUT_CYCLES (4),
        .CNT_WIDTH      (8)
    ) dut (
        .wb_clk_i   (wb_clk_i),
        .wb_rst_n_i (wb_rst_n_i),
        .m0_dat_i   (m0_dat_i),
        .m0_adr_i   (m0_adr_i),
        .m0_sel_i   (m0_sel_i),
        .m0_we_i    (m0_we_i),
        .m0_cyc_i   (m0_cyc_i),
        .m0_stb_i   (m0_stb_i),
        .m0_dat_o   (m0_dat_o),
        .m0_ack_o   (m0_ack_o),
        .m0_err_o   (m0_err_o),
        .m1_dat_i   (m1_dat_i),
        .m1_adr_i   (m1_adr_i),
        .m1_sel_i   (m1_sel_i),
        .m1_we_i    (m1_we_i),
        .m1_cyc_i   (m1_cyc_i),
        .m1_stb_i   (m1_stb_i),
        .m1_dat_o   (m1_dat_o),
        .m1_ack_o   (m1_ack_o),
        .m1_err_o   (m1_err_o),
        .s_dat_o    (s_dat_o),
        .s_adr_o    (s_adr_o),
        .s_sel_o    (s_sel_o),
        .s_we_o     (s_we_o),
        .s_cyc_o    (s_cyc_o),
        .s_stb_o    (s_stb_o),
        .s_dat_i    (s_dat_i),
        .s_ack_i    (s_ack_i),
        .s_err_i    (s_err_i)
    );

    // Single-port RAM slave: registered read data and ack one cycle after strobe.
    always @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            ram_ack <= 1'b0;
            for (int i = 0; i < 16; i++) ram[i] <= 32'h0;
            ram[4] <= 32'hDEADBEEF;
            ram[8] <= 32'hAABBCCDD;
        end else begin
            ram_ack <= s_cyc_o && s_stb_o && !ram_ack && ram_en;
            if (s_cyc_o && s_stb_o && !ram_ack && ram_en) begin
                ram_rdata <= ram[s_adr_o[5:2]];
                if (s_we_o) begin
                    for (int b = 0; b < 4; b++)
                        if (s_sel_o[b]) ram[s_adr_o[5:2]][8*b +: 8] <= s_dat_o[8*b +: 8];
                end
            end
        end
    end

    assign s_ack_i = ram_en ? ram_ack : force_ack;
    assign s_err_i = force_err;
    assign s_dat_i = ram_rdata;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge wb_clk_i);
        #2;
    endtask

    task automatic drive_m0(input logic cyc, input logic we, input logic [31:0] adr,
                            input logic [31:0] dat, input logic [3:0] sel);
        m0_cyc_i = cyc; m0_stb_i = cyc; m0_we_i = we;
        m0_adr_i = adr; m0_dat_i = dat; m0_sel_i = sel;
    endtask

    task automatic drive_m1(input logic cyc, input logic we, input logic [31:0] adr,
                            input logic [31:0] dat, input logic [3:0] sel);
        m1_cyc_i = cyc; m1_stb_i = cyc; m1_we_i = we;
        m1_adr_i = adr; m1_dat_i = dat; m1_sel_i = sel;
    endtask

    task automatic do_reset;
        wb_rst_n_i = 1'b0;
        tick();
        tick();
        wb_rst_n_i = 1'b1;
        tick();
    endtask

    initial begin
        wb_rst_n_i = 1'b0;
        ram_en     = 1'b1;
        force_ack  = 1'b0;
        force_err  = 1'b0;
        drive_m0(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        drive_m1(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        tick();
        check("rst_s_cyc", s_cyc_o, 0);
        check("rst_s_stb", s_stb_o, 0);
        check("rst_s_adr", s_adr_o, 0);
        check("rst_m0_ack", m0_ack_o, 0);
        check("rst_m1_err", m1_err_o, 0);
        tick();
        wb_rst_n_i = 1'b1;
        tick();

        // m0 read alone: grant after 1 cycle, ack one cycle later
        drive_m0(1'b1, 1'b0, 32'h10, 32'h0, 4'hF);
        #1 check("t1_cyc_before_grant", s_cyc_o, 0);
        tick();
        check("t1_s_cyc", s_cyc_o, 1);
        check("t1_s_adr", s_adr_o, 32'h10);
        check("t1_ack_early", m0_ack_o, 0);
        tick();
        check("t1_m0_ack", m0_ack_o, 1);
        check("t1_m0_dat", m0_dat_o, 32'hDEADBEEF);
        check("t1_m1_ack", m1_ack_o, 0);
        drive_m0(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        tick();
        check("t1_release", s_cyc_o, 0);

        // simultaneous requests after reset: m0 first, then round-robin
        do_reset();
        drive_m0(1'b1, 1'b0, 32'h10, 32'h0, 4'hF);
        drive_m1(1'b1, 1'b0, 32'h20, 32'h0, 4'hF);
        tick();
        check("t2_first_m0", s_adr_o, 32'h10);
        tick();
        check("t2_m0_ack", m0_ack_o, 1);
        check("t2_m1_noack", m1_ack_o, 0);
        drive_m0(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        tick();
        check("t2_none_gap", s_cyc_o, 0);
        drive_m0(1'b1, 1'b0, 32'h10, 32'h0, 4'hF);
        tick();
        check("t2_rr_m1_cyc", s_cyc_o, 1);
        check("t2_rr_m1_adr", s_adr_o, 32'h20);
        tick();
        check("t2_m1_ack", m1_ack_o, 1);
        check("t2_m1_dat", m1_dat_o, 32'hAABBCCDD);
        check("t2_m0_blocked", m0_ack_o, 0);
        drive_m1(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        tick();
        check("t2_none_gap2", s_cyc_o, 0);
        tick();
        check("t2_m0_again", s_adr_o, 32'h10);
        tick();
        check("t2_m0_ack2", m0_ack_o, 1);
        drive_m0(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        tick();

        // m1 partial write, then m0 reads back merged word
        drive_m1(1'b1, 1'b1, 32'h20, 32'h11223344, 4'b0011);
        tick();
        check("t3_s_adr", s_adr_o, 32'h20);
        check("t3_s_dat", s_dat_o, 32'h11223344);
        check("t3_s_sel", s_sel_o, 4'b0011);
        check("t3_s_we", s_we_o, 1);
        check("t3_s_stb", s_stb_o, 1);
        tick();
        check("t3_m1_ack", m1_ack_o, 1);
        drive_m1(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        tick();
        drive_m0(1'b1, 1'b0, 32'h20, 32'h0, 4'hF);
        tick();
        tick();
        check("t3_rd_ack", m0_ack_o, 1);
        check("t3_rd_dat", m0_dat_o, 32'hAABB3344);
        drive_m0(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        tick();

        // silent slave: timeout err exactly 4 cycles after grant
        ram_en = 1'b0;
        drive_m0(1'b1, 1'b0, 32'h10, 32'h0, 4'hF);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("t4_no_err_yet", m0_err_o, 0);
        end
        tick();
        check("t4_err_pulse", m0_err_o, 1);
        check("t4_stb_at_pulse", s_stb_o, 1);
        check("t4_m1_err", m1_err_o, 0);
        tick();
        check("t4_err_once", m0_err_o, 0);
        check("t4_stb_blocked", s_stb_o, 0);
        check("t4_cyc_held", s_cyc_o, 1);
        drive_m0(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        tick();
        check("t4_release", s_cyc_o, 0);

        // slave ack on the terminal cycle beats the timeout
        drive_m1(1'b1, 1'b0, 32'h20, 32'h0, 4'hF);
        for (int i = 0; i < 4; i++) tick();
        tick();
        force_ack = 1'b1;
        #1;
        check("t5_ack_wins", m1_ack_o, 1);
        check("t5_no_tmo_err", m1_err_o, 0);
        tick();
        force_ack = 1'b0;
        #1;
        check("t5_stb_live", s_stb_o, 1);
        check("t5_err_quiet", m1_err_o, 0);
        drive_m1(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        tick();

        // slave err is routed only to the owner
        drive_m0(1'b1, 1'b0, 32'h10, 32'h0, 4'hF);
        tick();
        force_err = 1'b1;
        #1;
        check("t6_m0_err", m0_err_o, 1);
        check("t6_m1_err", m1_err_o, 0);
        force_err = 1'b0;
        drive_m0(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        tick();
        ram_en = 1'b1;

        // reset mid-transfer
        drive_m0(1'b1, 1'b0, 32'h10, 32'h0, 4'hF);
        tick();
        check("t7_granted", s_cyc_o, 1);
        #1 wb_rst_n_i = 1'b0;
        #1;
        check("t7_async_cyc", s_cyc_o, 0);
        check("t7_async_ack", m0_ack_o, 0);
        check("t7_async_err", m0_err_o, 0);
        tick();
        check("t7_no_ack", m0_ack_o, 0);
        drive_m0(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        tick();
        wb_rst_n_i = 1'b1;
        tick();
        drive_m0(1'b1, 1'b0, 32'h10, 32'h0, 4'hF);
        drive_m1(1'b1, 1'b0, 32'h20, 32'h0, 4'hF);
        tick();
        check("t7_m0_first", s_adr_o, 32'h10);
        tick();
        check("t7_m0_ack", m0_ack_o, 1);
        check("t7_m0_dat", m0_dat_o, 32'hDEADBEEF);
        drive_m0(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        drive_m1(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/wishbone_arbiter_2m1s.md
Name: wishbone_arbiter_2m1s

Overview:
Two-master, one-slave Wishbone arbiter placed directly upstream of the OR10 32-bit single-port synchronous RAM slave. Masters are the CPU data bus (m0) and the instruction bus (m1). The arbiter grants one master at a time with round-robin fairness, muxes its request onto the slave, and routes ack/err back. A bus-timeout counter returns err to the granted master if the slave never responds.

Parameters:
TIMEOUT_CYCLES, 255, cycles after grant with stb high and no slave ack/err before a timeout err is generated; 0 disables the timeout.
CNT_WIDTH, 8, timeout counter width; must hold TIMEOUT_CYCLES.

Ports:
wb_clk_i  in  1  single clock, rising edge
wb_rst_n_i  in  1  asynchronous active-low reset
m0_dat_i, m1_dat_i  in  32  master write data
m0_adr_i, m1_adr_i  in  32  master byte address
m0_sel_i, m1_sel_i  in  4  byte enables
m0_we_i, m1_we_i  in  1  write enable
m0_cyc_i, m1_cyc_i  in  1  cycle request; held for the whole transfer
m0_stb_i, m1_stb_i  in  1  strobe
m0_dat_o, m1_dat_o  out  32  read data; both driven from s_dat_i
m0_ack_o, m1_ack_o  out  1  ack; only the granted master sees it
m0_err_o, m1_err_o  out  1  err from the slave or from a timeout
s_dat_o, s_adr_o  out  32  to slave
s_sel_o  out  4  to slave
s_we_o, s_cyc_o, s_stb_o  out  1  to slave
s_dat_i  in  32  slave read data
s_ack_i, s_err_i  in  1  slave response

Behaviour:
- Reset (async assert, sync deassert by design convention): grant=NONE, last_grant=M1 (so m0 wins the first tie), counter=0, timed_out=0.
- During reset all s_* outputs are 0, and every m*_ack_o/err_o is 0.
- State (grant register):
  - NONE -> M0 if m0_cyc_i and (!m1_cyc_i or last_grant==M1).
  - NONE -> M1 if m1_cyc_i and (!m0_cyc_i or last_grant==M0).
  - M0/M1 held while the granted master's cyc_i is 1; on its cyc_i=0 -> NONE and last_grant updated.
- No direct M0->M1 switch: there is always at least one NONE cycle with s_cyc_o=0 between owners.
- Grant takes effect one cycle after cyc_i is seen, so arbitration latency is 1 cycle. The RAM responds 1 cycle later, giving 2 cycles cyc->ack.
- Slave side is combinational from the grant register:
  - In NONE: s_cyc_o=s_stb_o=s_we_o=0; s_sel_o=0; s_adr_o=0; s_dat_o=0.
  - Otherwise the granted master's signals pass through.
  - s_stb_o is forced to 0 while timed_out=1.
- Master side:
  - Granted ack_o = s_ack_i.
  - Granted err_o = s_err_i | timeout_pulse.
  - Ungranted master: ack_o=err_o=0.
- Timeout:
  - Counter clears on grant change, on s_ack_i or s_err_i, and when the granted stb_i=0.
  - Otherwise it increments, saturating.
  - When it reaches TIMEOUT_CYCLES: timeout_pulse=1 for exactly one cycle and timed_out=1.
  - timed_out clears when grant returns to NONE.
  - Slave ack/err arriving on the same cycle as the timeout: slave response wins and no timeout err is issued.
- Pipelined back-to-back strobes within one cyc: each ack is routed and the counter restarts per strobe.
- Reset mid-transfer: grant drops immediately, s_cyc_o=0 asynchronously, and the pending master gets no ack.

Decomposition:
- Shared package wb_arbiter_pkg:
  - grant encoding localparams GNT_NONE=2'b00, GNT_M0=2'b01, GNT_M1=2'b10;
  - default TIMEOUT_CYCLES constant.
- One natural sub-module: wb_timeout_counter (clear, enable, terminal-count pulse, saturation), instantiated once.

Test Plan:
- m0 read alone, adr=0x10, RAM holds 0xDEADBEEF:
  - s_cyc_o rises 1 cycle after m0_cyc_i, m0_ack_o 1 cycle later;
  - m0_dat_o=0xDEADBEEF, m1_ack_o stays 0.
- Both cyc raised on the same cycle after reset:
  - m0 granted first; after m0 drops cyc, one NONE cycle, then m1 granted.
  - Next simultaneous request grants m1 first.
- m1 write adr=0x20, dat=0x11223344, sel=4'b0011:
  - s_* mirror m1 exactly;
  - subsequent m0 read of 0x20 returns 0x????3344, with bytes [31:16] unchanged from before.
- Slave held non-responding, TIMEOUT_CYCLES=4:
  - granted master gets err_o=1 for one cycle, 4 cycles after grant;
  - s_stb_o goes 0 until the master drops cyc.
- Slave ack on exactly the timeout cycle -> ack only, no err.
- Assert wb_rst_n_i=0 mid-transfer (cyc high, before ack):
  - s_cyc_o and all ack/err go 0 immediately;
  - after release, the first request is granted to m0.
